// File: rtl/id_ex_exe_stage.sv
// rtl/id_ex_exe_stage.sv - ID/EX pipeline register, EXE-stage ALU and EX/MEM pipeline register
module id_ex_exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_in,
  input  logic        Flush_in,
  input  logic        ID_valid_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] Imm_in,
  input  logic [4:0]  Rd_in,
  input  logic [1:0]  EXE_forwarding_in,
  input  logic        Ctl_ALUSrc_in,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic [3:0]  Ctl_ALUOp_in,
  input  logic [31:0] MEM_ReadData_in,
  output logic        EXE_Ctl_MemtoReg_out,
  output logic        EXE_Ctl_RegWrite_out,
  output logic [4:0]  EXE_Rd_out,
  output logic [31:0] ALUresult_out,
  output logic        Zero_out,
  output logic        MEM_valid_out,
  output logic        MEM_Ctl_MemtoReg_out,
  output logic        MEM_Ctl_RegWrite_out,
  output logic        MEM_Ctl_MemRead_out,
  output logic        MEM_Ctl_MemWrite_out,
  output logic [31:0] MEM_ALUresult_out,
  output logic [31:0] MEM_WriteData_out,
  output logic [4:0]  MEM_Rd_out
);

  // ID/EX register fields
  logic        ex_valid;
  logic        ex_alusrc;
  logic        ex_memtoreg;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [3:0]  ex_aluop;
  logic [1:0]  ex_fwd;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;

  // EXE-stage datapath
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] store_data;
  logic [31:0] alu_result;

  // ID/EX: reset or flush loads a bubble (data zeroed too), stall holds, otherwise capture
  always_ff @(posedge clk) begin
    if (rst || Flush_in) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_aluop    <= 4'd0;
      ex_fwd      <= 2'd0;
      ex_rd1      <= 32'd0;
      ex_rd2      <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rd       <= 5'd0;
    end else if (!Stall_in) begin
      ex_valid    <= ID_valid_in;
      ex_alusrc   <= Ctl_ALUSrc_in;
      ex_memtoreg <= Ctl_MemtoReg_in & ID_valid_in;
      // writes to x0 are dropped here so later stages never see them
      ex_regwrite <= Ctl_RegWrite_in & ID_valid_in & (Rd_in != 5'd0);
      ex_memread  <= Ctl_MemRead_in & ID_valid_in;
      ex_memwrite <= Ctl_MemWrite_in & ID_valid_in;
      ex_aluop    <= Ctl_ALUOp_in;
      ex_fwd      <= EXE_forwarding_in;
      ex_rd1      <= ReadData1_in;
      ex_rd2      <= ReadData2_in;
      ex_imm      <= Imm_in;
      ex_rd       <= Rd_in;
    end
  end

  // Operand selection with load-data forwarding, then the ALU
  always_comb begin
    op_a       = ex_fwd[0] ? MEM_ReadData_in : ex_rd1;
    store_data = ex_fwd[1] ? MEM_ReadData_in : ex_rd2;
    op_b       = ex_alusrc ? ex_imm : store_data;
    alu_result = 32'd0;
    case (ex_aluop)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a & op_b;
      4'd3:    alu_result = op_a | op_b;
      4'd4:    alu_result = op_a ^ op_b;
      4'd5:    alu_result = op_a << op_b[4:0];
      4'd6:    alu_result = op_a >> op_b[4:0];
      4'd7:    alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'd8:    alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_result = {31'd0, (op_a < op_b)};
      4'd10:   alu_result = op_b;
      default: alu_result = 32'd0;
    endcase
  end

  assign ALUresult_out        = alu_result;
  assign Zero_out             = (alu_result == 32'd0);
  assign EXE_Ctl_MemtoReg_out = ex_memtoreg;
  assign EXE_Ctl_RegWrite_out = ex_regwrite;
  assign EXE_Rd_out           = ex_rd;

  // EX/MEM: reset clears, stall holds, otherwise capture the EXE result
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_valid_out        <= 1'b0;
      MEM_Ctl_MemtoReg_out <= 1'b0;
      MEM_Ctl_RegWrite_out <= 1'b0;
      MEM_Ctl_MemRead_out  <= 1'b0;
      MEM_Ctl_MemWrite_out <= 1'b0;
      MEM_ALUresult_out    <= 32'd0;
      MEM_WriteData_out    <= 32'd0;
      MEM_Rd_out           <= 5'd0;
    end else if (!Stall_in) begin
      MEM_valid_out        <= ex_valid;
      MEM_Ctl_MemtoReg_out <= ex_memtoreg;
      MEM_Ctl_RegWrite_out <= ex_regwrite;
      MEM_Ctl_MemRead_out  <= ex_memread;
      MEM_Ctl_MemWrite_out <= ex_memwrite;
      MEM_ALUresult_out    <= alu_result;
      MEM_WriteData_out    <= store_data;
      MEM_Rd_out           <= ex_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_exe_stage.sv
// tb/tb_id_ex_exe_stage.sv - directed scoreboard bench for id_ex_exe_stage
module tb_id_ex_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_in, Flush_in, ID_valid_in;
  logic [31:0] ReadData1_in, ReadData2_in, Imm_in, MEM_ReadData_in;
  logic [4:0]  Rd_in;
  logic [1:0]  EXE_forwarding_in;
  logic        Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
  logic [3:0]  Ctl_ALUOp_in;
  logic        EXE_Ctl_MemtoReg_out, EXE_Ctl_RegWrite_out;
  logic [4:0]  EXE_Rd_out;
  logic [31:0] ALUresult_out;
  logic        Zero_out;
  logic        MEM_valid_out, MEM_Ctl_MemtoReg_out, MEM_Ctl_RegWrite_out;
  logic        MEM_Ctl_MemRead_out, MEM_Ctl_MemWrite_out;
  logic [31:0] MEM_ALUresult_out, MEM_WriteData_out;
  logic [4:0]  MEM_Rd_out;

  id_ex_exe_stage dut (
    .clk(clk), .rst(rst), .Stall_in(Stall_in), .Flush_in(Flush_in), .ID_valid_in(ID_valid_in),
    .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .Imm_in(Imm_in), .Rd_in(Rd_in),
    .EXE_forwarding_in(EXE_forwarding_in), .Ctl_ALUSrc_in(Ctl_ALUSrc_in),
    .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
    .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
    .Ctl_ALUOp_in(Ctl_ALUOp_in), .MEM_ReadData_in(MEM_ReadData_in),
    .EXE_Ctl_MemtoReg_out(EXE_Ctl_MemtoReg_out), .EXE_Ctl_RegWrite_out(EXE_Ctl_RegWrite_out),
    .EXE_Rd_out(EXE_Rd_out), .ALUresult_out(ALUresult_out), .Zero_out(Zero_out),
    .MEM_valid_out(MEM_valid_out), .MEM_Ctl_MemtoReg_out(MEM_Ctl_MemtoReg_out),
    .MEM_Ctl_RegWrite_out(MEM_Ctl_RegWrite_out), .MEM_Ctl_MemRead_out(MEM_Ctl_MemRead_out),
    .MEM_Ctl_MemWrite_out(MEM_Ctl_MemWrite_out), .MEM_ALUresult_out(MEM_ALUresult_out),
    .MEM_WriteData_out(MEM_WriteData_out), .MEM_Rd_out(MEM_Rd_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        v, m2r, rw, mr, mw;
  } mem_t;

  mem_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << s;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_valid_in = 1'b0; ReadData1_in = '0; ReadData2_in = '0; Imm_in = '0; Rd_in = '0;
    EXE_forwarding_in = '0; Ctl_ALUSrc_in = 1'b0; Ctl_MemtoReg_in = 1'b0; Ctl_RegWrite_in = 1'b0;
    Ctl_MemRead_in = 1'b0; Ctl_MemWrite_in = 1'b0; Ctl_ALUOp_in = '0;
  endtask

  // Drive a valid instruction into ID and push its expected EX/MEM contents
  task automatic issue(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [1:0] fwd, input logic alusrc,
                       input logic m2r, input logic rw, input logic mr, input logic mw,
                       input logic [3:0] op, input logic [31:0] md);
    mem_t e;
    logic [31:0] a, b, sd;
    ID_valid_in = 1'b1; ReadData1_in = rd1; ReadData2_in = rd2; Imm_in = imm; Rd_in = rd;
    EXE_forwarding_in = fwd; Ctl_ALUSrc_in = alusrc; Ctl_MemtoReg_in = m2r; Ctl_RegWrite_in = rw;
    Ctl_MemRead_in = mr; Ctl_MemWrite_in = mw; Ctl_ALUOp_in = op; MEM_ReadData_in = md;
    a  = fwd[0] ? md : rd1;
    sd = fwd[1] ? md : rd2;
    b  = alusrc ? imm : sd;
    e.alu = alu_model(op, a, b);
    e.wd  = sd;
    e.rd  = rd;
    e.v   = 1'b1;
    e.m2r = m2r;
    e.rw  = rw && (rd != 5'd0);
    e.mr  = mr;
    e.mw  = mw;
    exp_q.push_back(e);
  endtask

  task automatic check_mem();
    mem_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("mem_alu", MEM_ALUresult_out, e.alu);
      chk("mem_wd", MEM_WriteData_out, e.wd);
      chk("mem_rd", {27'd0, MEM_Rd_out}, {27'd0, e.rd});
      chk("mem_ctl", {27'd0, MEM_valid_out, MEM_Ctl_MemtoReg_out, MEM_Ctl_RegWrite_out,
                      MEM_Ctl_MemRead_out, MEM_Ctl_MemWrite_out},
                     {27'd0, e.v, e.m2r, e.rw, e.mr, e.mw});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_exe"}, {25'd0, EXE_Ctl_MemtoReg_out, EXE_Ctl_RegWrite_out, EXE_Rd_out}, 32'd0);
    chk({tag, "_alu"}, ALUresult_out, 32'd0);
    chk({tag, "_zero"}, {31'd0, Zero_out}, 32'd1);
    chk({tag, "_memctl"}, {27'd0, MEM_valid_out, MEM_Ctl_MemtoReg_out, MEM_Ctl_RegWrite_out,
                           MEM_Ctl_MemRead_out, MEM_Ctl_MemWrite_out}, 32'd0);
    chk({tag, "_memdata"}, MEM_ALUresult_out | MEM_WriteData_out | {27'd0, MEM_Rd_out}, 32'd0);
  endtask

  logic [3:0]  t_op [13] = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12, 4'd0, 4'd8};
  logic [31:0] t_a  [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'h8000_0000,
                             32'hF0F0, 32'hF0F0, 32'hFFFF, 32'h1234, 32'd5, 32'hFFFF_FFFF, 32'd1};
  logic [31:0] t_b  [13] = '{32'd33, 32'd1, 32'd1, 32'd5, 32'd35, 32'd4,
                             32'hFF00, 32'h0F0F, 32'h0F0F, 32'h5678, 32'd6, 32'd1, 32'hFFFF_FFFF};
  logic [31:0] t_r  [13] = '{32'hC000_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'd8, 32'h0800_0000,
                             32'hF000, 32'hFFFF, 32'hF0F0, 32'h5678, 32'd0, 32'd0, 32'd0};

  initial begin
    // Reset dominates stall and flush while a valid instruction is presented
    rst = 1'b1; Stall_in = 1'b1; Flush_in = 1'b1; MEM_ReadData_in = 32'h55;
    idle();
    ID_valid_in = 1'b1; ReadData1_in = 32'd9; Ctl_RegWrite_in = 1'b1; Rd_in = 5'd4;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0; Stall_in = 1'b0; Flush_in = 1'b0;
    idle();
    tick();

    // ADD 5+7 -> x3
    issue(32'd5, 32'd7, 32'd0, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("add_alu", ALUresult_out, 32'd12);
    chk("add_exe_rd", {27'd0, EXE_Rd_out}, 32'd3);
    chk("add_exe_rw", {31'd0, EXE_Ctl_RegWrite_out}, 32'd1);
    chk("add_zero", {31'd0, Zero_out}, 32'd0);
    idle();
    tick();
    check_mem();

    // Load-use forwarding on operand A, tracking MEM_ReadData_in combinationally
    issue(32'hDEAD, 32'd0, 32'd4, 5'd5, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h100);
    tick();
    chk("lu_alu", ALUresult_out, 32'h104);
    MEM_ReadData_in = 32'h200;
    #1;
    chk("lu_track", ALUresult_out, 32'h204);
    MEM_ReadData_in = 32'h100;
    idle();
    tick();
    check_mem();

    // Store with forwarded store data
    issue(32'h1000, 32'h1111, 32'd8, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'hCAFE);
    tick();
    idle();
    tick();
    chk("st_wd", MEM_WriteData_out, 32'hCAFE);
    chk("st_mw", {31'd0, MEM_Ctl_MemWrite_out}, 32'd1);
    check_mem();

    // RegWrite to x0 is suppressed
    issue(32'd1, 32'd2, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("x0_exe_rw", {31'd0, EXE_Ctl_RegWrite_out}, 32'd0);
    idle();
    tick();
    check_mem();

    // Back-to-back ALU operations, one per cycle, MEM checked two edges after issue
    for (int i = 0; i <= 13; i++) begin
      if (i < 13)
        issue(t_a[i], t_b[i], 32'd0, 5'(i + 1), 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t_op[i], 32'd0);
      else
        idle();
      tick();
      if (i < 13) begin
        chk($sformatf("op%0d_alu_%0d", t_op[i], i), ALUresult_out, t_r[i]);
        chk($sformatf("op%0d_zero_%0d", t_op[i], i), {31'd0, Zero_out}, {31'd0, t_r[i] == 32'd0});
      end
      if (i >= 1) check_mem();
    end
    tick();

    // Stall three cycles, then flush+stall together, then release
    issue(32'd10, 32'd20, 32'd0, 5'd7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    issue(32'd1, 32'd2, 32'd0, 5'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    check_mem();
    issue(32'd100, 32'd200, 32'd0, 5'd9, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    void'(exp_q.pop_back());
    Stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_mem_alu_%0d", k), MEM_ALUresult_out, 32'd30);
      chk($sformatf("stall_mem_rd_%0d", k), {27'd0, MEM_Rd_out}, 32'd7);
      chk($sformatf("stall_exe_rd_%0d", k), {27'd0, EXE_Rd_out}, 32'd8);
      chk($sformatf("stall_alu_%0d", k), ALUresult_out, 32'd3);
    end
    Flush_in = 1'b1;
    tick();
    chk("flush_exe_rw", {31'd0, EXE_Ctl_RegWrite_out}, 32'd0);
    chk("flush_exe_m2r", {31'd0, EXE_Ctl_MemtoReg_out}, 32'd0);
    chk("flush_mem_alu", MEM_ALUresult_out, 32'd30);
    chk("flush_mem_valid", {31'd0, MEM_valid_out}, 32'd1);
    Stall_in = 1'b0; Flush_in = 1'b0;
    idle();
    void'(exp_q.pop_front());
    tick();
    chk("bubble_mem_ctl", {27'd0, MEM_valid_out, MEM_Ctl_MemtoReg_out, MEM_Ctl_RegWrite_out,
                           MEM_Ctl_MemRead_out, MEM_Ctl_MemWrite_out}, 32'd0);

    // Reset with a valid instruction in each stage
    issue(32'd5, 32'd6, 32'd0, 5'd4, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    tick();
    issue(32'd7, 32'd8, 32'd0, 5'd6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
    tick();
    rst = 1'b1;
    idle();
    tick();
    check_reset_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    tick();
    chk("post_rst_mem_valid", {31'd0, MEM_valid_out}, 32'd0);
    chk("post_rst_exe_rw", {31'd0, EXE_Ctl_RegWrite_out}, 32'd0);
    issue(32'd40, 32'd2, 32'd0, 5'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("post_rst_alu", ALUresult_out, 32'd42);
    idle();
    tick();
    check_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_exe_stage.md
ID_EX_EXE_STAGE -- requirements
Module: id_ex_exe_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Stall_in  in  1  freeze both pipeline registers
- Flush_in  in  1  insert bubble into ID/EX
- ID_valid_in  in  1  ID holds a real instruction
- ReadData1_in, ReadData2_in  in  32  register-file operands, already ALU/WB-forwarded
- Imm_in  in  32  sign-extended immediate
- Rd_in  in  5  destination register
- EXE_forwarding_in  in  2  bit0 = Rs1 needs load data, bit1 = Rs2 needs load data
- Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in  in  1 each  decoded controls
- Ctl_ALUOp_in  in  4  ALU operation
- MEM_ReadData_in  in  32  load data produced by MEM this cycle
- EXE_Ctl_MemtoReg_out, EXE_Ctl_RegWrite_out  out  1  EXE-stage controls, fed back to the register file
- EXE_Rd_out  out  5  EXE-stage Rd, fed back to the register file
- ALUresult_out  out  32  combinational ALU result of the EXE instruction
- Zero_out  out  1  ALUresult_out == 0
- MEM_valid_out, MEM_Ctl_MemtoReg_out, MEM_Ctl_RegWrite_out, MEM_Ctl_MemRead_out, MEM_Ctl_MemWrite_out  out  1 each  EX/MEM register
- MEM_ALUresult_out, MEM_WriteData_out  out  32  EX/MEM register
- MEM_Rd_out  out  5  EX/MEM register

Function
REQ-002 SHALL contain two register sets: ID/EX (inputs above) and EX/MEM (MEM_* outputs).
REQ-003 ID/EX update priority per edge SHALL be rst > Flush_in > Stall_in > capture.
REQ-004 Flush_in=1 SHALL load a bubble into ID/EX: valid=0, all Ctl_* =0, forwarding=0, data fields don't-care; this applies even when Stall_in=1.
REQ-005 Stall_in=1 (no flush) SHALL hold ID/EX; Stall_in=1 SHALL always hold EX/MEM.
REQ-006 On capture, RegWrite SHALL be stored as Ctl_RegWrite_in & ID_valid_in & (Rd_in!=0); MemRead, MemWrite and MemtoReg SHALL be ANDed with ID_valid_in.
REQ-007 Operand A SHALL be MEM_ReadData_in if stored forwarding bit0=1, else stored ReadData1.
REQ-008 Store data SHALL be MEM_ReadData_in if stored bit1=1, else stored ReadData2; operand B SHALL be Imm if ALUSrc=1, else store data.
REQ-009 ALUOp SHALL encode 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 PASS-B; 11-15 SHALL yield 0.
REQ-010 Shifts SHALL use B[4:0] only. ADD/SUB SHALL wrap modulo 2^32 with no overflow flag.
REQ-011 EXE_* outputs and ALUresult_out SHALL be combinational from ID/EX, with zero added latency, so the register file sees them in the same cycle.
REQ-012 EX/MEM, when not stalled, SHALL capture ALUresult, store data, Rd, valid and controls; latency from ID capture to MEM_* outputs is exactly 2 edges.
REQ-013 A bubble SHALL propagate to EX/MEM with all MEM_Ctl_* =0 and MEM_valid_out=0.
REQ-014 During Stall_in=1, MEM_ReadData_in is guaranteed stable by the environment; the forwarded operand SHALL track it combinationally.

Reset
REQ-015 rst=1 at an edge SHALL clear every ID/EX and EX/MEM field to 0, giving all outputs 0 and Zero_out=1; rst overrides Stall_in and Flush_in.
REQ-016 Deasserting rst mid-stream SHALL resume capture on the first edge with rst=0; no instruction held before reset SHALL reappear.

Verification
REQ-017 The bench SHALL cover:
- ADD with RD1=5, RD2=7, ALUSrc=0, Rd=3 -> ALUresult_out=12 after edge 1; MEM_ALUresult_out=12, MEM_Rd_out=3 after edge 2.
- Load-use: forwarding=01, RD1=0xDEAD, MEM_ReadData_in=0x100, Imm=4, ALUSrc=1, ADD -> ALUresult_out=0x104.
- Store with forwarding=10, MEM_ReadData_in=0xCAFE -> MEM_WriteData_out=0xCAFE, MEM_Ctl_MemWrite_out=1.
- Stall 3 cycles, then Flush_in and Stall_in together -> EX/MEM unchanged during the stall; ID/EX bubble gives EXE_Ctl_RegWrite_out=0.
- Rd_in=0 with RegWrite=1 -> EXE_Ctl_RegWrite_out=0. SRA 0x80000000 by 33 -> 0xC0000000. SLT -1<1 -> 1; SLTU -> 0.
- rst asserted while a valid instruction is in each stage -> all outputs 0 on the next edge.
